// File: rtl/ssd_pkg.sv
// Shared types and the hex-to-seven-segment decoder for PmodSSD drivers.
package ssd_pkg;

    typedef logic [6:0] t_ssd_seg;

    localparam t_ssd_seg SEG_BLANK = 7'h00;

    // Hex nibble to segments a..g (bit0 = a), active-high.
    function automatic t_ssd_seg hex_to_ssd(input logic [3:0] hex);
        t_ssd_seg seg;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h67;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_refresh_tick.sv
// Free-running divider producing a one-cycle tick every DIVISOR cycles.
// The tick is high while the counter sits at DIVISOR-1.
module ssd_refresh_tick #(
    parameter int unsigned DIVISOR = 200000
) (
    input  logic i_clk_20mhz,
    input  logic i_rst_20mhz,
    output logic o_tick
);

    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("ssd_refresh_tick: DIVISOR must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_s;

    // Next count: wrap to zero after the tick cycle.
    always_comb begin
        tick_s = (cnt_q == CNT_LAST);
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = tick_s;

endmodule

// File: rtl/multi_pmod_ssd_display.sv
// Multi-device PmodSSD driver on a single clock with a refresh tick enable.
// Values are captured into a pending register and committed only at a frame
// boundary (select going 1->0), so a display never mixes nibbles of two loads.
// Optional feature macro: SSD_DIMMING_EN (adds i_brightness and a PWM stage).
module multi_pmod_ssd_display
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_SSD    = 2,
    parameter int unsigned CLK_HZ     = 20000000,
    parameter int unsigned REFRESH_HZ = 100,
    parameter bit          LZ_BLANK   = 1'b0
) (
    input  logic                 i_clk_20mhz,
    input  logic                 i_rst_20mhz,
    input  logic [8*NUM_SSD-1:0] i_value,
    input  logic                 i_load,
    input  logic [NUM_SSD-1:0]   i_blank,
`ifdef SSD_DIMMING_EN
    input  logic [2:0]           i_brightness,
`endif
    output logic                 o_busy,
    output logic [8*NUM_SSD-1:0] o_ssd_pmod
);

    localparam int unsigned TICK_DIV = CLK_HZ / REFRESH_HZ;

    generate
        if (TICK_DIV < 2) begin : g_bad_tick_div
            $error("multi_pmod_ssd_display: CLK_HZ/REFRESH_HZ must be at least 2");
        end
        if ((NUM_SSD < 1) || (NUM_SSD > 8)) begin : g_bad_num_ssd
            $error("multi_pmod_ssd_display: NUM_SSD must be 1..8");
        end
    endgenerate

    logic                 tick_s;
    logic                 commit_s;
    logic                 sel_q,     sel_d;
    logic                 busy_q,    busy_d;
    logic [8*NUM_SSD-1:0] pending_q, pending_d;
    logic [8*NUM_SSD-1:0] active_q,  active_d;
    logic [8*NUM_SSD-1:0] pmod_q,    pmod_d;
    t_ssd_seg             dev_seg_s [NUM_SSD];

    ssd_refresh_tick #(
        .DIVISOR (TICK_DIV)
    ) u_tick (
        .i_clk_20mhz (i_clk_20mhz),
        .i_rst_20mhz (i_rst_20mhz),
        .o_tick      (tick_s)
    );

    // Select toggle, load capture and frame-boundary commit.
    always_comb begin
        sel_d     = sel_q;
        busy_d    = busy_q;
        pending_d = pending_q;
        active_d  = active_q;
        commit_s  = tick_s && sel_q && (busy_q || i_load);
        if (tick_s) begin
            sel_d = ~sel_q;
        end else begin
            sel_d = sel_q;
        end
        if (commit_s) begin
            // A load landing on the commit tick bypasses pending entirely.
            if (i_load) begin
                active_d = i_value;
            end else begin
                active_d = pending_q;
            end
            busy_d = 1'b0;
        end else if (i_load) begin
            pending_d = i_value;
            busy_d    = 1'b1;
        end else begin
            busy_d = busy_q;
        end
    end

    // Per-device segment pattern for the post-commit value and new select.
    genvar k;
    generate
        for (k = 0; k < NUM_SSD; k++) begin : g_dev
            always_comb begin
                if (sel_d) begin
                    dev_seg_s[k] = hex_to_ssd(active_d[8*k+4 +: 4]);
                end else begin
                    dev_seg_s[k] = hex_to_ssd(active_d[8*k +: 4]);
                end
                if (i_blank[k]) begin
                    dev_seg_s[k] = SEG_BLANK;
                end else if (LZ_BLANK && sel_d && (active_d[8*k+4 +: 4] == 4'h0)) begin
                    dev_seg_s[k] = SEG_BLANK;
                end else begin
                    dev_seg_s[k] = dev_seg_s[k];
                end
            end
        end
    endgenerate

    // Output bus only changes on tick; holds otherwise.
    always_comb begin
        pmod_d = pmod_q;
        for (int i = 0; i < NUM_SSD; i++) begin
            if (tick_s) begin
                pmod_d[8*i +: 8] = {sel_d, dev_seg_s[i]};
            end else begin
                pmod_d[8*i +: 8] = pmod_q[8*i +: 8];
            end
        end
    end

    // Control and display state registers.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= '0;
            active_q  <= '0;
            pmod_q    <= '0;
        end else begin
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            pmod_q    <= pmod_d;
        end
    end

    assign o_busy = busy_q;

`ifdef SSD_DIMMING_EN
    logic [2:0]           phase_q, phase_d;
    logic                 gate_s;
    logic [8*NUM_SSD-1:0] dim_q,   dim_d;

    // PWM gate: segments enabled while phase is at or below brightness.
    always_comb begin
        phase_d = phase_q + 3'd1;
        gate_s  = (phase_q <= i_brightness);
        dim_d   = '0;
        for (int i = 0; i < NUM_SSD; i++) begin
            dim_d[8*i+7]  = pmod_q[8*i+7];
            dim_d[8*i +: 7] = pmod_q[8*i +: 7] & {7{gate_s}};
        end
    end

    // Phase counter and gated output stage.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            phase_q <= 3'd0;
            dim_q   <= '0;
        end else begin
            phase_q <= phase_d;
            dim_q   <= dim_d;
        end
    end

    assign o_ssd_pmod = dim_q;
`else
    assign o_ssd_pmod = pmod_q;
`endif

endmodule

// File: tb/tb_multi_pmod_ssd_display.sv
// Directed bench for multi_pmod_ssd_display with TICK_DIV = 10, NUM_SSD = 2.
// A second instance runs with leading-zero blanking enabled.
module tb_multi_pmod_ssd_display;

`ifdef SSD_DIMMING_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] val, val2;
    logic        load, load2;
    logic [1:0]  blank;
    logic        busy, busy2;
    logic [15:0] pmod, pmod2;
`ifdef SSD_DIMMING_EN
    logic [2:0]  bright;
`endif

    int cyc;
    int total;
    int passed;
    int seen06;
    int seen66;
    logic mon_en;

    always #5 clk = ~clk;

    multi_pmod_ssd_display #(
        .NUM_SSD(2), .CLK_HZ(1000), .REFRESH_HZ(100), .LZ_BLANK(1'b0)
    ) dut (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .i_value     (val),
        .i_load      (load),
        .i_blank     (blank),
`ifdef SSD_DIMMING_EN
        .i_brightness(bright),
`endif
        .o_busy      (busy),
        .o_ssd_pmod  (pmod)
    );

    multi_pmod_ssd_display #(
        .NUM_SSD(2), .CLK_HZ(1000), .REFRESH_HZ(100), .LZ_BLANK(1'b1)
    ) dut_lz (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .i_value     (val2),
        .i_load      (load2),
        .i_blank     (2'b00),
`ifdef SSD_DIMMING_EN
        .i_brightness(3'd7),
`endif
        .o_busy      (busy2),
        .o_ssd_pmod  (pmod2)
    );

    // Watch for digits '1' and '4' on the main instance (never to be shown).
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (pmod[8*k +: 7] == 7'h06) seen06 <= seen06 + 1;
                if (pmod[8*k +: 7] == 7'h66) seen66 <= seen66 + 1;
            end
        end
    end

    typedef struct {
        int          cyc;
        logic        ld;
        logic [15:0] v;
        logic [1:0]  bl;
        logic        ld2;
        logic [15:0] ep;
        logic        eb;
        logic        cl;
        logic [15:0] el;
    } vec_t;

    vec_t tv[$];

    task automatic add(input int c, input logic ld, input logic [15:0] v,
                       input logic [1:0] bl, input logic ld2, input logic [15:0] ep,
                       input logic eb, input logic cl, input logic [15:0] el);
        vec_t r;
        r.cyc = c; r.ld = ld; r.v = v; r.bl = bl; r.ld2 = ld2;
        r.ep = ep; r.eb = eb; r.cl = cl; r.el = el;
        tv.push_back(r);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int on_cnt;

    initial begin
        total = 0; passed = 0; seen06 = 0; seen66 = 0; mon_en = 1'b0;
        rst = 1'b1; val = 16'h0000; val2 = 16'h0507; load = 1'b0; load2 = 1'b0;
        blank = 2'b00;
`ifdef SSD_DIMMING_EN
        bright = 3'd7;
`endif

        //   cyc      ld    value     blank  ld2   exp_pmod  busy  chk_lz lz_exp
        add(0,        1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000);
        add(2,        1'b0, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        add(9 + LAT,  1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000);
        add(10 + LAT, 1'b0, 16'h0000, 2'b00, 1'b0, 16'hBFBF, 1'b0, 1'b1, 16'h8080);
        add(15,       1'b0, 16'h0000, 2'b00, 1'b0, 16'hBFBF, 1'b0, 1'b1, 16'h8080);
        add(22,       1'b0, 16'h0000, 2'b00, 1'b0, 16'h3F3F, 1'b0, 1'b0, 16'h0000);
        add(25,       1'b0, 16'h0000, 2'b00, 1'b0, 16'h3F3F, 1'b0, 1'b1, 16'h6D07);
        add(33,       1'b1, 16'hA35C, 2'b00, 1'b0, 16'hBFBF, 1'b0, 1'b1, 16'h8080);
        add(34,       1'b0, 16'hA35C, 2'b00, 1'b0, 16'hBFBF, 1'b1, 1'b0, 16'h0000);
        add(39,       1'b0, 16'hA35C, 2'b00, 1'b0, 16'hBFBF, 1'b1, 1'b0, 16'h0000);
        add(41,       1'b0, 16'hA35C, 2'b00, 1'b0, 16'h4F39, 1'b0, 1'b0, 16'h0000);
        add(55,       1'b0, 16'hA35C, 2'b00, 1'b0, 16'hF7ED, 1'b0, 1'b0, 16'h0000);
        add(62,       1'b1, 16'h1111, 2'b00, 1'b0, 16'h4F39, 1'b0, 1'b0, 16'h0000);
        add(63,       1'b0, 16'h1111, 2'b00, 1'b0, 16'h4F39, 1'b1, 1'b0, 16'h0000);
        add(65,       1'b1, 16'h2222, 2'b00, 1'b0, 16'h4F39, 1'b1, 1'b0, 16'h0000);
        add(75,       1'b0, 16'h2222, 2'b00, 1'b0, 16'hF7ED, 1'b1, 1'b0, 16'h0000);
        add(85,       1'b0, 16'h2222, 2'b00, 1'b0, 16'h5B5B, 1'b0, 1'b0, 16'h0000);
        add(95,       1'b0, 16'h2222, 2'b00, 1'b0, 16'hDBDB, 1'b0, 1'b0, 16'h0000);
        add(99,       1'b1, 16'h0F0F, 2'b00, 1'b0, 16'hDBDB, 1'b0, 1'b0, 16'h0000);
        add(101,      1'b0, 16'h0F0F, 2'b00, 1'b0, 16'h7171, 1'b0, 1'b0, 16'h0000);
        add(105,      1'b0, 16'h0F0F, 2'b10, 1'b0, 16'h7171, 1'b0, 1'b0, 16'h0000);
        add(115,      1'b0, 16'h0F0F, 2'b10, 1'b0, 16'h80BF, 1'b0, 1'b0, 16'h0000);
        add(125,      1'b0, 16'h0F0F, 2'b00, 1'b0, 16'h0071, 1'b0, 1'b0, 16'h0000);
        add(135,      1'b0, 16'h0F0F, 2'b00, 1'b0, 16'hBFBF, 1'b0, 1'b0, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        mon_en = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            while (cyc < tv[i].cyc) step();
            val   = tv[i].v;
            blank = tv[i].bl;
            load  = tv[i].ld;
            load2 = tv[i].ld2;
            check("pmod", pmod, tv[i].ep);
            check("busy", {15'd0, busy}, {15'd0, tv[i].eb});
            if (tv[i].cl) check("pmod_lz", pmod2, tv[i].el);
            step();
            load  = 1'b0;
            load2 = 1'b0;
        end

        // Reset while busy discards the pending value.
        val  = 16'h4444;
        load = 1'b1;
        step();
        load = 1'b0;
        check("busy_before_rst", {15'd0, busy}, 16'h0001);
        rst = 1'b1;
        step();
        check("busy_after_rst", {15'd0, busy}, 16'h0000);
        check("pmod_after_rst", pmod, 16'h0000);
        check("pmod_lz_after_rst", pmod2, 16'h0000);
        rst = 1'b0;
        cyc = 0;
        while (cyc < 25) step();
        check("pmod_post_rst", pmod, 16'h3F3F);
        check("pmod_lz_post_rst", pmod2, 16'h3F3F);

`ifdef SSD_DIMMING_EN
        while (cyc < 29) step();
        bright = 3'd3;
        while (cyc < 31) step();
        on_cnt = 0;
        for (int j = 0; j < 8; j++) begin
            if (pmod[6:0] != 7'h00) on_cnt++;
            step();
        end
        check("dim_on_cycles", 16'(on_cnt), 16'd4);
        bright = 3'd7;
`else
        on_cnt = 0;
`endif

        step();
        mon_en = 1'b0;
        check("digit1_never_shown", 16'(seen06), 16'd0);
        check("digit4_never_shown", 16'(seen66), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
